// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: frame marker, FSM states and
// length-byte decoding.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StCheck,
    StDone,
    StErr
  } state_e;

  // A length byte of 0 encodes a full 256-byte program.
  function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready byte stream carrying program frames into the loader.
interface prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/prog_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// No reset; contents are undefined after power-up.
module prog_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: stores a checksummed program into the
// instruction RAM and holds the CPU in reset until a valid frame has landed.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = prog_loader_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset_n,
  prog_loader_if.slave      rx,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_instr,
  output logic              o_cpu_reset,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_prog_len
);
  import prog_loader_pkg::*;

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_e          r_state;
  logic            r_rx_ready;
  logic            r_cpu_reset;
  logic            r_load_done;
  logic            r_load_err;
  logic [ADDR_W:0] r_prog_len;
  // One bit wider than the address so a 256-byte frame ends without wrapping.
  logic [ADDR_W:0] r_idx;
  logic [7:0]      r_sum;

  logic            w_xfer;
  logic            w_sync;
  logic            w_last;
  logic            w_we;
  logic [7:0]      w_sum_next;

  assign w_xfer     = rx.rx_valid && r_rx_ready;
  assign w_sync     = (rx.rx_data == SYNC_BYTE);
  assign w_last     = ((r_idx + IDX_ONE) == r_prog_len);
  assign w_we       = (r_state == StData) && w_xfer;
  assign w_sum_next = r_sum + rx.rx_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_rx_ready  <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_prog_len  <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer && w_sync) r_state <= StLen;
        end
        StLen: begin
          if (w_xfer) begin
            r_prog_len <= decode_len(rx.rx_data);
            r_idx      <= '0;
            r_sum      <= '0;
            r_state    <= StData;
          end
        end
        StData: begin
          if (w_xfer) begin
            r_idx <= r_idx + IDX_ONE;
            r_sum <= w_sum_next;
            if (w_last) r_state <= StCsum;
          end
        end
        StCsum: begin
          if (w_xfer) begin
            r_sum      <= w_sum_next;
            r_state    <= StCheck;
            r_rx_ready <= 1'b0;
          end
        end
        StCheck: begin
          r_rx_ready <= 1'b1;
          if (r_sum == 8'd0) begin
            r_state     <= StDone;
            r_cpu_reset <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_state    <= StErr;
            r_load_err <= 1'b1;
          end
        end
        StDone, StErr: begin
          // Reassert CPU reset before any RAM byte of the new frame is written.
          if (w_xfer && w_sync) begin
            r_state     <= StLen;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx[ADDR_W-1:0]),
    .i_wdata (rx.rx_data),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_instr)
  );

  assign rx.rx_ready  = r_rx_ready;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;
  assign o_prog_len   = r_prog_len;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven frames plus directed
// sequences for backpressure, full depth, reload and mid-frame reset.
module tb_prog_loader;

  logic       clk;
  logic       reset_n;
  logic [7:0] rd_addr;
  logic [7:0] rd_instr;
  logic       cpu_reset;
  logic       load_done;
  logic       load_err;
  logic [8:0] prog_len;

  int n_checks;
  int n_err;

  prog_loader_if rx_if ();

  prog_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx_if),
    .i_rd_addr   (rd_addr),
    .o_rd_instr  (rd_instr),
    .o_cpu_reset (cpu_reset),
    .o_load_done (load_done),
    .o_load_err  (load_err),
    .o_prog_len  (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       rdy;
    logic       crst;
    logic       done;
    logic       err;
    logic [8:0] len;
    logic       fin;
    logic       fin_done;
    logic       fin_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a byte and return #1 after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_if.rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_if.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_ram(input logic [7:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    check($sformatf("ram[%0d]", addr), {24'd0, rd_instr}, {24'd0, exp});
  endtask

  task automatic check_status(input string name, input logic rdy, input logic crst,
                              input logic done, input logic err);
    check({name, ".rx_ready"}, {31'd0, rx_if.rx_ready}, {31'd0, rdy});
    check({name, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, crst});
    check({name, ".load_done"}, {31'd0, load_done}, {31'd0, done});
    check({name, ".load_err"}, {31'd0, load_err}, {31'd0, err});
  endtask

  task automatic frame(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) begin
      if (gaps) idle($urandom_range(0, 2));
      send(bytes[i]);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    n_checks = 0;
    n_err    = 0;

    //          b      rdy  crst done err len  fin fdone ferr
    vecs[0]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h9D, 1'b0, 1'b1, 1'b0, 1'b0, 9'd3, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9'd2, 1'b1, 1'b0, 1'b1};

    reset_n        = 1'b0;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    rd_addr        = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset.prog_len", {23'd0, prog_len}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic load followed by a bad-checksum reload.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].b);
      check_status($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].crst, vecs[i].done,
                   vecs[i].err);
      check($sformatf("vec%0d.prog_len", i), {23'd0, prog_len}, {23'd0, vecs[i].len});
      if (vecs[i].fin) begin
        @(posedge clk);
        #1;
        check_status($sformatf("vec%0d.fin", i), 1'b1, ~vecs[i].fin_done, vecs[i].fin_done,
                     vecs[i].fin_err);
      end
    end
    check_ram(8'd0, 8'h11);
    check_ram(8'd1, 8'h12);
    check_ram(8'd2, 8'h40);

    // Junk in ERR is discarded; a gappy valid frame then recovers.
    send(8'h00);
    send(8'h7F);
    check_status("err_junk", 1'b1, 1'b1, 1'b0, 1'b1);
    q = '{8'hA5, 8'h03, 8'h11, 8'h12, 8'h40, 8'h9D};
    frame(q, 1'b1);
    check_status("gaps.check", 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_status("gaps.done", 1'b1, 1'b0, 1'b1, 1'b0);
    check("gaps.prog_len", {23'd0, prog_len}, 32'd3);
    check_ram(8'd0, 8'h11);
    check_ram(8'd1, 8'h12);
    check_ram(8'd2, 8'h40);

    // One-byte reload: cpu_reset must rise on the sync accept edge.
    send(8'hA5);
    check_status("reload.sync", 1'b1, 1'b1, 1'b0, 1'b0);
    q = '{8'h01, 8'h7E, 8'h82};
    frame(q, 1'b0);
    idle(1);
    check_status("reload.done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_ram(8'd0, 8'h7E);
    check_ram(8'd1, 8'h12);
    check_ram(8'd2, 8'h40);

    // Full 256-byte frame, with a read-during-write probe at address 1.
    send(8'hA5);
    send(8'h00);
    check("full.prog_len", {23'd0, prog_len}, 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (i == 1) begin
        check_ram(8'd1, 8'h12);
        send(8'h01);
        check("full.rdw_new", {24'd0, rd_instr}, 32'h01);
      end else begin
        send(i[7:0]);
      end
    end
    send(8'h80);
    idle(1);
    check_status("full.done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_ram(8'd255, 8'hFF);
    check_ram(8'd128, 8'h80);
    check_ram(8'd0, 8'h00);

    // Asynchronous reset in the middle of a frame.
    send(8'hA5);
    send(8'h02);
    send(8'h33);
    reset_n = 1'b0;
    #1;
    check_status("midreset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("midreset.prog_len", {23'd0, prog_len}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_ram(8'd0, 8'h33);
    q = '{8'h00, 8'h7F, 8'hA5, 8'h02, 8'h44, 8'h55, 8'h67};
    frame(q, 1'b0);
    idle(1);
    check_status("after_reset.done", 1'b1, 1'b0, 1'b1, 1'b0);
    check("after_reset.prog_len", {23'd0, prog_len}, 32'd2);
    check_ram(8'd0, 8'h44);
    check_ram(8'd1, 8'h55);
    check_ram(8'd2, 8'h02);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
